// File: rtl/menu_ctrl.sv
// Menu navigation FSM: keyboard cursor with auto-repeat, enter/confirm/lock handshake.
// Optional pointer support is enabled with `define MENU_MOUSE_EN (needs snake_pkg button geometry).
module menu_ctrl #(
  parameter int NUM_ITEMS   = 3,
  parameter int REPEAT_DLY  = 20_000_000,
  parameter int REPEAT_RATE = 8_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        menu_en,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_enter,
  input  logic        key_back,
`ifdef MENU_MOUSE_EN
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic [0:0]  mouse_left,
`endif
  output logic [1:0]  cursor,
  output logic        sel_valid,
  output logic [1:0]  sel_item,
  output logic        locked
);

  typedef enum logic [1:0] {IDLE, BROWSE, CONFIRM, LOCKED} state_t;

  localparam int              CNT_W    = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
  localparam logic [CNT_W-1:0] FIRST_AT = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] NEXT_AT  = CNT_W'(REPEAT_DLY + REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(REPEAT_DLY);
  localparam logic [1:0]       LAST     = 2'(NUM_ITEMS - 1);

  state_t           r_state;
  logic [1:0]       r_cursor;
  logic [1:0]       r_sel_item;
  logic             r_sel_valid;
  logic             r_locked;
  logic [CNT_W-1:0] r_rpt_cnt;
  logic             r_rpt_act;
  logic             r_up_q, r_dn_q, r_ent_q, r_back_q;

  logic w_up_rise, w_dn_rise, w_ent_rise, w_back_rise;
  logic w_single, w_ud_edge, w_rpt_due, w_rpt_keep;
  logic w_hit, w_click;
  logic [1:0] w_hit_idx;

  function automatic logic [1:0] cur_inc(input logic [1:0] c);
    return (c == LAST) ? 2'd0 : c + 2'd1;
  endfunction

  function automatic logic [1:0] cur_dec(input logic [1:0] c);
    return (c == 2'd0) ? LAST : c - 2'd1;
  endfunction

  // History registers reset to 1, so a key held through reset or state entry is not an edge.
  assign w_up_rise   = key_up    & ~r_up_q;
  assign w_dn_rise   = key_down  & ~r_dn_q;
  assign w_ent_rise  = key_enter & ~r_ent_q;
  assign w_back_rise = key_back  & ~r_back_q;
  assign w_single    = key_up ^ key_down;
  assign w_ud_edge   = (w_up_rise | w_dn_rise) & ~(key_up & key_down);
  assign w_rpt_keep  = r_rpt_act & w_single;
  assign w_rpt_due   = w_rpt_keep & ((r_rpt_cnt == FIRST_AT) | (r_rpt_cnt == NEXT_AT));

`ifdef MENU_MOUSE_EN
  logic r_ml_q;

  function automatic int btn_y(input int i);
    case (i)
      0:       return int'(snake_pkg::BUTTON1_Y);
      1:       return int'(snake_pkg::BUTTON2_Y);
      default: return int'(snake_pkg::BUTTON3_Y);
    endcase
  endfunction

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = 2'd0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (int'(mouse_xpos) >= int'(snake_pkg::BUTTONS_X) &&
          int'(mouse_xpos) <  int'(snake_pkg::BUTTONS_X) + int'(snake_pkg::BUTTONS_W) &&
          int'(mouse_ypos) >= btn_y(i) &&
          int'(mouse_ypos) <  btn_y(i) + int'(snake_pkg::BUTTONS_H)) begin
        w_hit     = 1'b1;
        w_hit_idx = 2'(i);
      end
    end
  end

  assign w_click = mouse_left[0] & ~r_ml_q & w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ml_q <= 1'b1;
    else     r_ml_q <= mouse_left[0];
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_idx = 2'd0;
  assign w_click   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cursor    <= 2'd0;
      r_sel_item  <= 2'd0;
      r_sel_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_rpt_cnt   <= '0;
      r_rpt_act   <= 1'b0;
      r_up_q      <= 1'b1;
      r_dn_q      <= 1'b1;
      r_ent_q     <= 1'b1;
      r_back_q    <= 1'b1;
    end else begin
      r_up_q      <= key_up;
      r_dn_q      <= key_down;
      r_ent_q     <= key_enter;
      r_back_q    <= key_back;
      r_sel_valid <= 1'b0;
      r_rpt_cnt   <= '0;
      r_rpt_act   <= 1'b0;
      if (!menu_en) begin
        r_state  <= IDLE;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state  <= BROWSE;
            r_cursor <= 2'd0;
          end
          BROWSE: begin
            // Keyboard takes priority over the pointer; enter beats a coincident up/down edge.
            if (w_ent_rise) begin
              r_state     <= CONFIRM;
              r_sel_item  <= r_cursor;
              r_sel_valid <= 1'b1;
              r_locked    <= 1'b1;
            end else if (w_ud_edge) begin
              r_cursor  <= w_up_rise ? cur_dec(r_cursor) : cur_inc(r_cursor);
              r_rpt_act <= 1'b1;
            end else if (w_rpt_keep) begin
              r_rpt_act <= 1'b1;
              r_rpt_cnt <= (r_rpt_cnt == NEXT_AT) ? RELOAD : r_rpt_cnt + 1'b1;
              if (w_rpt_due)
                r_cursor <= key_up ? cur_dec(r_cursor) : cur_inc(r_cursor);
            end else if (w_click) begin
              r_state     <= CONFIRM;
              r_cursor    <= w_hit_idx;
              r_sel_item  <= w_hit_idx;
              r_sel_valid <= 1'b1;
              r_locked    <= 1'b1;
            end else if (w_hit) begin
              r_cursor <= w_hit_idx;
            end
          end
          CONFIRM: r_state <= LOCKED;
          LOCKED: begin
            if (w_back_rise) begin
              r_state  <= BROWSE;
              r_locked <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign cursor    = r_cursor;
  assign sel_valid = r_sel_valid;
  assign sel_item  = r_sel_item;
  assign locked    = r_locked;

endmodule

// File: tb/tb_menu_ctrl.sv
// Self-checking bench for menu_ctrl: vector table, hand-written corner sequences,
// and a randomized run compared against a behavioural model.
module tb_menu_ctrl;
  localparam int N    = 3;
  localparam int DLY  = 10;
  localparam int RATE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       menu_en = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_enter = 1'b0, key_back = 1'b0;
  logic [1:0] cursor, sel_item;
  logic       sel_valid, locked;

  int n_chk  = 0;
  int n_fail = 0;

  menu_ctrl #(.NUM_ITEMS(N), .REPEAT_DLY(DLY), .REPEAT_RATE(RATE)) dut (
    .clk(clk), .rst(rst), .menu_en(menu_en),
    .key_up(key_up), .key_down(key_down), .key_enter(key_enter), .key_back(key_back),
    .cursor(cursor), .sel_valid(sel_valid), .sel_item(sel_item), .locked(locked)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 idle, 1 browsing, 2 confirming, 3 locked.
  int m_mode, m_cur, m_sel, m_vld, m_lk, m_age;
  bit p_up, p_dn, p_ent, p_bk;

  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_sel = 0; m_vld = 0; m_lk = 0; m_age = -1;
    p_up = 1; p_dn = 1; p_ent = 1; p_bk = 1;
  endtask

  function automatic int move(input int c, input bit up);
    return up ? (c + N - 1) % N : (c + 1) % N;
  endfunction

  task automatic model_step();
    bit ur, dr, er, br;
    ur = key_up && !p_up;
    dr = key_down && !p_dn;
    er = key_enter && !p_ent;
    br = key_back && !p_bk;
    m_vld = 0;
    if (!menu_en) begin
      m_mode = 0; m_lk = 0; m_age = -1;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_cur = 0; m_age = -1; end
        1: begin
          if (er) begin
            m_mode = 2; m_sel = m_cur; m_vld = 1; m_lk = 1; m_age = -1;
          end else if ((ur || dr) && !(key_up && key_down)) begin
            m_cur = move(m_cur, ur); m_age = 0;
          end else if (m_age >= 0 && (key_up != key_down)) begin
            m_age++;
            if (m_age == DLY || (m_age > DLY && (m_age - DLY) % RATE == 0))
              m_cur = move(m_cur, key_up);
          end else begin
            m_age = -1;
          end
        end
        2: begin m_mode = 3; m_age = -1; end
        default: begin
          m_age = -1;
          if (br) begin m_mode = 1; m_lk = 0; end
        end
      endcase
    end
    p_up = key_up; p_dn = key_down; p_ent = key_enter; p_bk = key_back;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int v, input int it, input int lk);
    check({tag, ".cursor"}, int'(cursor), c);
    check({tag, ".sel_valid"}, int'(sel_valid), v);
    check({tag, ".sel_item"}, int'(sel_item), it);
    check({tag, ".locked"}, int'(locked), lk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic set_keys(input logic u, input logic d, input logic e, input logic b);
    key_up = u; key_down = d; key_enter = e; key_back = b;
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1; menu_en = 1'b0; set_keys(0, 0, 0, 0);
    #1 chk_all("reset_async", 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_all("reset_hold", 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic en, up, dn, ent, bk;
    int   cur, vld, item, lk;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic up, input logic dn, input logic ent,
                              input logic bk, input int cur, input int vld, input int item,
                              input int lk);
    vec_t v;
    v.en = en; v.up = up; v.dn = dn; v.ent = ent; v.bk = bk;
    v.cur = cur; v.vld = vld; v.item = item; v.lk = lk;
    return v;
  endfunction

  vec_t tbl[24];
  int   steps_at[6] = '{1, 11, 15, 19, 23, 27};

  initial begin
    //            en up dn en bk  cur vld item lk
    tbl[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 0, 0,  1, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0,  1, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, 0, 0,  2, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0,  2, 0, 0, 0);
    tbl[5]  = mk(1, 0, 1, 0, 0,  0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 0, 0,  2, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0,  2, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 1, 0,  2, 1, 2, 1);
    tbl[10] = mk(1, 0, 0, 0, 0,  2, 0, 2, 1);
    tbl[11] = mk(1, 0, 1, 0, 0,  2, 0, 2, 1);
    tbl[12] = mk(1, 0, 0, 0, 0,  2, 0, 2, 1);
    tbl[13] = mk(1, 0, 0, 0, 1,  2, 0, 2, 0);
    tbl[14] = mk(1, 0, 0, 0, 0,  2, 0, 2, 0);
    tbl[15] = mk(1, 0, 1, 0, 0,  0, 0, 2, 0);
    tbl[16] = mk(1, 0, 0, 0, 0,  0, 0, 2, 0);
    tbl[17] = mk(1, 0, 1, 0, 0,  1, 0, 2, 0);
    tbl[18] = mk(1, 0, 0, 0, 0,  1, 0, 2, 0);
    tbl[19] = mk(1, 0, 1, 1, 0,  1, 1, 1, 1);
    tbl[20] = mk(1, 0, 0, 0, 0,  1, 0, 1, 1);
    tbl[21] = mk(1, 0, 0, 0, 1,  1, 0, 1, 0);
    tbl[22] = mk(1, 0, 0, 0, 0,  1, 0, 1, 0);
    tbl[23] = mk(0, 0, 0, 0, 0,  1, 0, 1, 0);

    reset_dut();
    for (int i = 0; i < 24; i++) begin
      menu_en = tbl[i].en;
      set_keys(tbl[i].up, tbl[i].dn, tbl[i].ent, tbl[i].bk);
      step();
      chk_all($sformatf("tbl%0d", i), tbl[i].cur, tbl[i].vld, tbl[i].item, tbl[i].lk);
    end

    // Auto-repeat: hold key_down for 30 cycles starting from cursor 0.
    reset_dut();
    menu_en = 1'b1;
    step();
    set_keys(0, 1, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      int n;
      step();
      n = 0;
      foreach (steps_at[j]) if (steps_at[j] <= k) n++;
      check($sformatf("repeat_k%0d", k), int'(cursor), n % N);
    end
    set_keys(0, 0, 0, 0);
    step();
    check("repeat_release", int'(cursor), 0);

    // Both up and down held: no movement, no repeat.
    set_keys(1, 1, 0, 0);
    for (int k = 0; k < 14; k++) step();
    check("both_held", int'(cursor), 0);
    set_keys(0, 0, 0, 0);
    step();

    // Reset lands on the same cycle as enter+down rising at cursor 1.
    set_keys(0, 1, 0, 0); step();
    set_keys(0, 0, 0, 0); step();
    check("pre_rst_cursor", int'(cursor), 1);
    rst = 1'b1;
    set_keys(0, 1, 1, 0);
    #1 chk_all("rst_coincident", 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_all("rst_coincident_hold", 0, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    step();
    chk_all("after_rst_enter", 0, 0, 0, 0);
    // Keys still held from before entry must not act as edges.
    for (int k = 0; k < 14; k++) begin
      step();
      check("held_on_entry.sel_valid", int'(sel_valid), 0);
    end
    check("held_on_entry.cursor", int'(cursor), 0);
    set_keys(0, 0, 0, 0);
    step();

    // Reset while in the confirm cycle drops the pulse.
    set_keys(0, 0, 1, 0);
    step();
    chk_all("confirm_pulse", 0, 1, 0, 1);
    rst = 1'b1;
    #1 chk_all("rst_in_confirm", 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      check("no_pulse_after_rst", int'(sel_valid), 0);
    end

    // Randomized run against the behavioural model.
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      menu_en = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 7) == 0)  key_up    = ~key_up;
      if ($urandom_range(0, 7) == 0)  key_down  = ~key_down;
      if ($urandom_range(0, 19) == 0) key_enter = ~key_enter;
      if ($urandom_range(0, 9) == 0)  key_back  = ~key_back;
      step();
      chk_all($sformatf("rand%0d", c), m_cur, m_vld, m_sel, m_lk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/menu_ctrl.md
MENU_CTRL -- requirements
Module: menu_ctrl

Interface
REQ-001 Parameter NUM_ITEMS, default 3: number of menu entries; cursor range 0..NUM_ITEMS-1.
REQ-002 Parameter REPEAT_DLY, default 20_000_000: cycles an up/down key is held before auto-repeat starts.
REQ-003 Parameter REPEAT_RATE, default 8_000_000: cycles between auto-repeat steps once repeating.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 menu_en  in  1  high while the menu screen is shown.
REQ-007 key_up / key_down / key_enter / key_back  in  1 each  synchronous key levels, high = pressed.
REQ-008 cursor  out  2  index of the highlighted button, consumed by the menu drawing path.
REQ-009 sel_valid  out  1  one-cycle pulse; a menu entry was chosen.
REQ-010 sel_item  out  2  entry chosen; valid while sel_valid is high, held afterwards.
REQ-011 locked  out  1  high from selection until release by key_back or menu_en low.

Function
REQ-012 FSM states: IDLE, BROWSE, CONFIRM, LOCKED.
REQ-013 IDLE -> BROWSE when menu_en=1; cursor forced to 0 on that transition.
REQ-014 Any state -> IDLE when menu_en=0, next cycle; sel_valid stays 0 and locked clears.
REQ-015 Rising edge of key_up in BROWSE: cursor decrements; 0 wraps to NUM_ITEMS-1.
REQ-016 Rising edge of key_down in BROWSE: cursor increments; NUM_ITEMS-1 wraps to 0.
REQ-017 Cursor updates one cycle after the key edge is sampled.
REQ-018 Key held in BROWSE: first repeat step REPEAT_DLY cycles after the edge, then one step every REPEAT_RATE cycles; counter clears on release.
REQ-019 key_up and key_down both high or both rising in the same cycle: no cursor move; repeat counter held at 0.
REQ-020 Rising edge of key_enter in BROWSE: -> CONFIRM; sel_item latches the current cursor value.
REQ-021 key_enter edge coincident with an up/down edge: enter wins; the cursor does not move; sel_item = the pre-move cursor value.
REQ-022 CONFIRM lasts exactly one cycle: sel_valid=1, then -> LOCKED.
REQ-023 In LOCKED: cursor frozen, up/down/enter ignored, locked=1.
REQ-024 Rising edge of key_back in LOCKED: -> BROWSE; cursor is kept.
REQ-025 Keys already high on entry to BROWSE do not count as edges; the key must be released and pressed again.

Reset
REQ-026 While rst=1: state=IDLE, cursor=0, sel_valid=0, sel_item=0, locked=0, repeat counter=0, edge history registers=1 (treated as pressed).
REQ-027 rst asserted mid-repeat or in CONFIRM: the pending sel_valid pulse is dropped; no pulse after rst deasserts.

Configuration
REQ-028 Macro MENU_MOUSE_EN adds inputs mouse_xpos[11:0], mouse_ypos[11:0] and mouse_left[0:0].
REQ-029 With the macro, in BROWSE the pointer inside a button rectangle (BUTTONS_X, BUTTONn_Y, BUTTONS_W, BUTTONS_H from snake_pkg, bounds inclusive of x/y, exclusive of x+W/y+H) sets cursor to that button.
REQ-030 With the macro, a rising edge of mouse_left inside a button is treated as key_enter.
REQ-031 With the macro, if a key edge and a mouse action occur in the same cycle, the key wins.
REQ-032 Without the macro, the mouse ports do not exist and behaviour is keyboard-only.

Verification
REQ-033 Reset, then menu_en=1, key_down pulse x2 -> cursor 0->1->2; one more pulse -> cursor 0.
REQ-034 cursor=0, key_up pulse -> cursor=2; key_enter pulse -> sel_valid high exactly 1 cycle, sel_item=2, locked=1.
REQ-035 In LOCKED, key_down pulse -> cursor unchanged; key_back pulse -> BROWSE, locked=0, cursor=2.
REQ-036 REPEAT_DLY=10, REPEAT_RATE=4: hold key_down for 30 cycles from cursor=0 -> steps at +1, +11, +15, +19, +23, +27 -> cursor=0 (6 steps mod 3).
REQ-037 key_enter and key_down rise together at cursor=1 -> sel_item=1, cursor stays 1; rst asserted the same cycle instead -> no sel_valid, all outputs 0.
REQ-038 With MENU_MOUSE_EN: pointer at (BUTTONS_X, BUTTON2_Y), mouse_left pulse -> cursor=1, sel_valid=1, sel_item=1; pointer at x=BUTTONS_X+BUTTONS_W -> no change.
